// File: rtl/perf_monitor.sv
// Pipeline performance monitor: cycle, stall and branch counters with halt/timeout capture
// and a registered one-cycle readback port.
//   state   | meaning
//   IDLE    | waiting for en, nothing counts
//   RUN     | counters advance
//   HALTED  | hlt seen, counters frozen until clear/reset
//   TIMEOUT | MAX_CYCLES reached, counters frozen until clear/reset
module perf_monitor #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 100000000
) (
    input  logic             input_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             stall,
    input  logic             br_resolved,
    input  logic             br_miss,
    input  logic             hlt,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] cycles_consumed,
    output logic [WIDTH-1:0] StallCount,
    output logic [WIDTH-1:0] BranchPredictionCount,
    output logic [WIDTH-1:0] BranchPredictionMissCount,
    output logic             halted,
    output logic             timeout,
    output logic             rd_ack,
    output logic [WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_t;

    // A limit that does not fit the counter is unreachable; the cycle counter just saturates.
    localparam logic [63:0]      LIMIT_WIDE = 64'(MAX_CYCLES) - 64'd1;
    localparam bit               TIMEOUT_ON = ((LIMIT_WIDE >> WIDTH) == 64'd0);
    localparam logic [WIDTH-1:0] LIMIT      = WIDTH'(LIMIT_WIDE);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cyc_d, stall_d, br_d, miss_d;
    logic [WIDTH-1:0] sel_val;

    function automatic logic [WIDTH-1:0] inc_sat(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_comb begin
        state_d = state_q;
        cyc_d   = cycles_consumed;
        stall_d = StallCount;
        br_d    = BranchPredictionCount;
        miss_d  = BranchPredictionMissCount;
        if (clear) begin
            state_d = IDLE;
            cyc_d   = '0;
            stall_d = '0;
            br_d    = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) state_d = RUN;
                end
                RUN: begin
                    if (stall) stall_d = inc_sat(StallCount);
                    if (br_resolved) begin
                        br_d = inc_sat(BranchPredictionCount);
                        if (br_miss) miss_d = inc_sat(BranchPredictionMissCount);
                    end
                    // hlt wins over a coincident timeout and leaves the cycle count untouched
                    if (hlt) begin
                        state_d = HALTED;
                    end else begin
                        cyc_d = inc_sat(cycles_consumed);
                        if (TIMEOUT_ON && (cycles_consumed == LIMIT)) state_d = TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_val = '0;
        case (rd_sel)
            2'd0: sel_val = cycles_consumed;
            2'd1: sel_val = StallCount;
            2'd2: sel_val = BranchPredictionCount;
            2'd3: sel_val = BranchPredictionMissCount;
            default: sel_val = '0;
        endcase
    end

    always_ff @(posedge input_clk or negedge rst) begin
        if (!rst) begin
            state_q                   <= IDLE;
            cycles_consumed           <= '0;
            StallCount                <= '0;
            BranchPredictionCount     <= '0;
            BranchPredictionMissCount <= '0;
            halted                    <= 1'b0;
            timeout                   <= 1'b0;
            rd_ack                    <= 1'b0;
            rd_data                   <= '0;
        end else begin
            state_q                   <= state_d;
            cycles_consumed           <= cyc_d;
            StallCount                <= stall_d;
            BranchPredictionCount     <= br_d;
            BranchPredictionMissCount <= miss_d;
            halted                    <= (state_d == HALTED);
            timeout                   <= (state_d == TIMEOUT);
            rd_ack                    <= rd_req;
            rd_data                   <= rd_req ? sel_val : '0;
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: directed vector table, corner-case sequences and
// randomized traffic against an arithmetic reference model.
module tb_perf_monitor;

    localparam int              W    = 32;
    localparam int              MAXC = 16;
    localparam longint unsigned MAXL = 64'd16;
    localparam longint unsigned SATV = 64'hFFFF_FFFF;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2, M_TIMEOUT = 3;

    logic clk = 1'b0;
    logic rst, en, clear, stall, br_resolved, br_miss, hlt, rd_req;
    logic [1:0]   rd_sel;
    logic [W-1:0] cyc, stl_cnt, br_cnt, ms_cnt, rd_data;
    logic         halted, timeout, rd_ack;
    logic [3:0]   n_cyc, n_stl, n_br, n_ms, n_rd_data;
    logic         n_halted, n_timeout, n_rd_ack;

    always #5 clk = ~clk;

    perf_monitor #(.WIDTH(W), .MAX_CYCLES(MAXC)) dut (
        .input_clk(clk), .rst(rst), .en(en), .clear(clear), .stall(stall),
        .br_resolved(br_resolved), .br_miss(br_miss), .hlt(hlt),
        .rd_req(rd_req), .rd_sel(rd_sel),
        .cycles_consumed(cyc), .StallCount(stl_cnt), .BranchPredictionCount(br_cnt),
        .BranchPredictionMissCount(ms_cnt), .halted(halted), .timeout(timeout),
        .rd_ack(rd_ack), .rd_data(rd_data)
    );

    // Narrow instance with an unreachable limit, used to exercise saturation.
    perf_monitor #(.WIDTH(4), .MAX_CYCLES(100)) dut_narrow (
        .input_clk(clk), .rst(rst), .en(en), .clear(clear), .stall(stall),
        .br_resolved(br_resolved), .br_miss(br_miss), .hlt(hlt),
        .rd_req(rd_req), .rd_sel(rd_sel),
        .cycles_consumed(n_cyc), .StallCount(n_stl), .BranchPredictionCount(n_br),
        .BranchPredictionMissCount(n_ms), .halted(n_halted), .timeout(n_timeout),
        .rd_ack(n_rd_ack), .rd_data(n_rd_data)
    );

    int total = 0;
    int bad   = 0;

    // Model: counters indexed by their readback select code.
    int              m_st;
    longint unsigned m_cnt [4];
    bit              m_ack;
    longint unsigned m_dat;

    typedef struct {
        int en, clr, stl, hlt, brr, brm, rdq, sel;
        longint e_cyc, e_stl, e_br, e_ms;
        int e_h, e_t, e_ack;
        longint e_dat;
    } vec_t;
    vec_t tbl [20];

    function automatic longint unsigned sat_inc(input longint unsigned x);
        return (x >= SATV) ? x : x + 64'd1;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE;
        for (int k = 0; k < 4; k++) m_cnt[k] = 64'd0;
        m_ack = 1'b0;
        m_dat = 64'd0;
    endtask

    task automatic model_step();
        m_ack = rd_req;
        m_dat = rd_req ? m_cnt[rd_sel] : 64'd0;
        if (clear) begin
            m_st = M_IDLE;
            for (int k = 0; k < 4; k++) m_cnt[k] = 64'd0;
        end else if (m_st == M_IDLE) begin
            if (en) m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (stall) m_cnt[1] = sat_inc(m_cnt[1]);
            if (br_resolved) m_cnt[2] = sat_inc(m_cnt[2]);
            if (br_resolved && br_miss) m_cnt[3] = sat_inc(m_cnt[3]);
            if (hlt) m_st = M_HALTED;
            else if (m_cnt[0] == MAXL - 64'd1) begin
                m_cnt[0] = MAXL;
                m_st     = M_TIMEOUT;
            end else m_cnt[0] = sat_inc(m_cnt[0]);
        end
    endtask

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " cycles"},  64'(cyc),     m_cnt[0]);
        check({tag, " stalls"},  64'(stl_cnt), m_cnt[1]);
        check({tag, " branch"},  64'(br_cnt),  m_cnt[2]);
        check({tag, " miss"},    64'(ms_cnt),  m_cnt[3]);
        check({tag, " halted"},  64'(halted),  64'(m_st == M_HALTED));
        check({tag, " timeout"}, 64'(timeout), 64'(m_st == M_TIMEOUT));
        check({tag, " rd_ack"},  64'(rd_ack),  64'(m_ack));
        check({tag, " rd_data"}, 64'(rd_data), m_dat);
    endtask

    task automatic drive(input int e, input int c, input int s, input int h,
                         input int br, input int bm, input int rq, input int sel);
        en          = (e != 0);
        clear       = (c != 0);
        stall       = (s != 0);
        hlt         = (h != 0);
        br_resolved = (br != 0);
        br_miss     = (bm != 0);
        rd_req      = (rq != 0);
        rd_sel      = 2'(sel);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input int e, input int c, input int s, input int h,
                        input int br, input int bm, input int rq, input int sel);
        drive(e, c, s, h, br, bm, rq, sel);
        check_all(tag);
    endtask

    initial begin
        //          en clr stl hlt brr brm rdq sel  cyc stl br ms  h  t  ack dat
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0,  0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 1, 0, 0, 0,   2, 1, 2, 0,  0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 1, 0, 0,   3, 1, 3, 1,  0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 0,   4, 1, 4, 1,  0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 1, 0, 0, 0,   5, 2, 5, 1,  0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 0,   6, 2, 6, 2,  0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 0, 0, 0,   7, 2, 7, 2,  0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 0,   8, 2, 8, 2,  0, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 1, 0, 0,   9, 3, 8, 2,  0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0,  10, 3, 8, 2,  0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 0, 0, 0,  10, 3, 8, 2,  1, 0, 0, 0};
        tbl[12] = '{1, 0, 1, 1, 1, 1, 0, 0,  10, 3, 8, 2,  1, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 1,  10, 3, 8, 2,  1, 0, 1, 3};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0,  10, 3, 8, 2,  1, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 0,  10, 3, 8, 2,  1, 0, 1, 10};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 1, 2,  10, 3, 8, 2,  1, 0, 1, 8};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 1, 3,  10, 3, 8, 2,  1, 0, 1, 2};
        tbl[18] = '{0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0};

        rst = 1'b0;
        en = 1'b0; clear = 1'b0; stall = 1'b0; hlt = 1'b0;
        br_resolved = 1'b0; br_miss = 1'b0; rd_req = 1'b0; rd_sel = 2'd0;
        model_reset();
        #20;
        check_all("reset");
        #2 rst = 1'b1;

        // Directed table: basic run, branches, hlt freeze, readback, clear.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].stl, tbl[i].hlt,
                  tbl[i].brr, tbl[i].brm, tbl[i].rdq, tbl[i].sel);
            check($sformatf("tbl[%0d] cycles", i),  64'(cyc),     64'(tbl[i].e_cyc));
            check($sformatf("tbl[%0d] stalls", i),  64'(stl_cnt), 64'(tbl[i].e_stl));
            check($sformatf("tbl[%0d] branch", i),  64'(br_cnt),  64'(tbl[i].e_br));
            check($sformatf("tbl[%0d] miss", i),    64'(ms_cnt),  64'(tbl[i].e_ms));
            check($sformatf("tbl[%0d] halted", i),  64'(halted),  64'(tbl[i].e_h));
            check($sformatf("tbl[%0d] timeout", i), 64'(timeout), 64'(tbl[i].e_t));
            check($sformatf("tbl[%0d] rd_ack", i),  64'(rd_ack),  64'(tbl[i].e_ack));
            check($sformatf("tbl[%0d] rd_data", i), 64'(rd_data), 64'(tbl[i].e_dat));
        end

        // Timeout, then a late hlt must not set halted.
        step("to clr", 0, 1, 0, 0, 0, 0, 0, 0);
        step("to en",  1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step("to run", 0, 0, 0, 0, 0, 0, 0, 0);
        check("to pre cycles",  64'(cyc), 64'd15);
        check("to pre timeout", 64'(timeout), 64'd0);
        step("to edge", 0, 0, 0, 0, 0, 0, 0, 0);
        check("to cycles",  64'(cyc), 64'd16);
        check("to timeout", 64'(timeout), 64'd1);
        step("to late hlt", 1, 0, 1, 1, 1, 1, 0, 0);
        check("to late halted", 64'(halted), 64'd0);
        check("to late cycles", 64'(cyc), 64'd16);

        // hlt on the edge that would reach the limit.
        step("col clr", 0, 1, 0, 0, 0, 0, 0, 0);
        step("col en",  1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step("col run", 0, 0, 0, 0, 0, 0, 0, 0);
        step("col hlt", 0, 0, 0, 1, 0, 0, 0, 0);
        check("col halted",  64'(halted), 64'd1);
        check("col timeout", 64'(timeout), 64'd0);
        check("col cycles",  64'(cyc), 64'd15);

        // Saturation on the 4-bit instance.
        step("sat clr", 0, 1, 0, 0, 0, 0, 0, 0);
        step("sat en",  1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("sat run", 0, 0, 1, 0, 1, 1, 0, 0);
        check("sat cycles",  64'(n_cyc), 64'd15);
        check("sat stalls",  64'(n_stl), 64'd15);
        check("sat branch",  64'(n_br),  64'd15);
        check("sat miss",    64'(n_ms),  64'd15);
        check("sat timeout", 64'(n_timeout), 64'd0);
        step("sat rd", 0, 0, 0, 0, 0, 0, 1, 1);
        check("sat rd_ack",  64'(n_rd_ack),  64'd1);
        check("sat rd_data", 64'(n_rd_data), 64'd15);
        step("sat hlt", 0, 0, 0, 1, 0, 0, 0, 0);
        check("sat halted", 64'(n_halted), 64'd1);

        // Asynchronous reset mid-RUN, held across an edge, then restart via en.
        step("ar clr", 0, 1, 0, 0, 0, 0, 0, 0);
        step("ar en",  1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("ar run", 0, 0, 1, 0, 1, 0, 0, 0);
        step("ar rd", 0, 0, 1, 0, 0, 0, 1, 0);
        check("ar rd_data pre", 64'(rd_data), 64'd4);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("ar async");
        en = 1'b1;
        @(posedge clk);
        #1;
        check_all("ar held");
        rst = 1'b1;
        step("ar idle", 0, 0, 0, 0, 0, 0, 0, 0);
        step("ar restart", 1, 0, 0, 0, 0, 0, 0, 0);
        step("ar count", 0, 0, 0, 0, 0, 0, 0, 0);
        check("ar count cycles", 64'(cyc), 64'd1);
        step("ar clr hlt", 0, 1, 1, 1, 1, 1, 0, 0);
        check("ar clr halted", 64'(halted), 64'd0);
        check("ar clr cycles", 64'(cyc), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step("rnd",
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 24) == 0),
                 int'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
